step_pulse_gen: RTL and testbench
=================================

# step_pulse_gen

Step-pulse generator feeding the pedometer counter/display FSM. It emits one-cycle `pulse` strobes at a rate chosen by `mode`: walk, jog, run, or a scripted 9-second hybrid profile. It also emits a one-cycle second boundary strobe, which the downstream stage uses for per-second statistics. Every rate produces exactly R pulses per second, evenly spaced.

## Interface
- `CLK_HZ`, default 100_000_000: clock frequency; defines one "second" as `CLK_HZ` cycles.
- `clk` input, 1 bit: system clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `run` input, 1 bit: level enable, synchronous to `clk`. Low stops all activity.
- `mode` input, 2 bits: 0 = walk (32/s), 1 = jog (64/s), 2 = run (128/s), 3 = hybrid.
- `pulse` output, 1 bit: one-cycle step strobe, registered.
- `sec_tick` output, 1 bit: one-cycle strobe on the last cycle of each completed second, registered.
- `hyb_sec` output, 4 bits: current hybrid second, 1..9. It reads 0 when not in HYBRID.
- `hyb_done` output, 1 bit: high while in DONE.

## Operation
- **States: IDLE, STEADY, HYBRID, DONE.**
  - IDLE: the second counter `sec_cnt` (0..CLK_HZ-1), period counter `per_cnt`, and emitted-pulse count `emit` are held at 0.
  - IDLE→STEADY when `run`=1 and `mode`≠3.
  - IDLE→HYBRID when `run`=1 and `mode`=3; `hyb_sec` is loaded with 1.
  - `run`=0 in any state goes to IDLE on the next cycle.
  - A change of `mode` while running restarts the run. Counters clear and the FSM re-enters STEADY or HYBRID as if from IDLE (`hyb_sec` is reloaded with 1). The new mode takes effect on the following cycle.
- **Rate R:** 32, 64 or 128 in STEADY. In HYBRID, R comes from `hyb_sec` using the schedule 20, 33, 66, 27, 70, 30, 19, 30, 33.
- **Period:** P = floor(CLK_HZ/R), computed from package constants, not by a runtime divider.
- **Per cycle while running:**
  - `sec_cnt` increments and wraps at CLK_HZ-1.
  - `per_cnt` increments and wraps at P-1.
  - When `per_cnt`=P-1 and `emit`<R, a pulse is issued and `emit` increments.
  - At the `sec_cnt` wrap, `per_cnt` and `emit` clear and `sec_tick` is issued.
  - Because P≤CLK_HZ/R, exactly R pulses occur per second. Cycles left over after pulse R are silent.
- **Hybrid advance:** at each second wrap, `hyb_sec` increments. The wrap that ends second 9 goes to DONE.
- **DONE:** no `pulse`, no `sec_tick`, `hyb_sec`=0, `hyb_done`=1. The FSM stays there until `run`=0 or `mode` changes.
- **Simultaneous events:**
  - A pulse and a second wrap can fall on the same cycle. Both strobes are issued, and the cleared counters apply from the next cycle.
  - A `run` fall takes priority over any pending strobe: no strobe is issued in that cycle.

## Timing
- **Reset values:** `pulse`=0, `sec_tick`=0, `hyb_sec`=0, `hyb_done`=0, state IDLE, all counters 0.
- **Run start:** `run` is sampled high at edge k. Counting starts at edge k+1. The first `pulse` is high in the cycle after edge k+P+1, i.e. P+1 cycles after sampling.
- **`sec_tick`:** high for one cycle, CLK_HZ cycles after counting starts, and every CLK_HZ cycles thereafter.
- **Strobe latency:** one registered stage from the counter condition to the output. Both `pulse` and `sec_tick` are never high for more than one consecutive cycle.
- **Run stop:** `run` low at edge k means outputs are 0 from the cycle after edge k+1.
- **`rst_n`:** asserting it at any time, mid-pulse included, forces reset values immediately.

## Configuration
- **`STEP_PULSE_HYBRID_EN`**
  - Defined: HYBRID and DONE states, the schedule table and `hyb_sec` logic are compiled in.
  - Undefined: `mode`=3 behaves like `run`=0 (stays in IDLE, no strobes), and `hyb_sec`/`hyb_done` are tied to 0.

## Structure
- **Package `step_pulse_pkg`:**
  - mode encodings and the state enum;
  - steady-rate constants 32/64/128;
  - the 9-entry hybrid rate table;
  - a function returning P for a given `CLK_HZ` and R.
- **Sub-module `step_period_counter`:** the `per_cnt`/`emit` counter with clear, wrap and cap logic, instantiated once. The top level owns the FSM, `sec_cnt` and the output registers.

## Test plan
All scenarios use `CLK_HZ`=1280, giving walk P=40, jog P=20, run P=10.
- **Walk:** `run`=1, `mode`=0 for 2 s → 64 pulses exactly 40 cycles apart; `sec_tick` at cycles 1280 and 2560 after start.
- **Hybrid rate 33:** `mode`=3 for 10 s → per-second pulse counts 20, 33, 66, 27, 70, 30, 19, 30, 33. The rate-33 seconds (P=38) have no pulse in the last 26 cycles. Then `hyb_done`=1 with no further strobes.
- **Mode change:** switch from run to jog at cycle 500 → counters restart; the next pulse comes 21 cycles after the change; `sec_tick` is realigned.
- **Run drop:** `run` 1→0 in the cycle where `per_cnt`=P-1 → no pulse issued; the FSM is in IDLE with counters 0.
- **Async reset:** assert `rst_n`=0 mid-second, asynchronously between edges → all outputs 0 before the next edge; after release, `run`=1 behaves as a fresh start.
- **Macro undefined:** `mode`=3 with `run`=1 for 2 s → zero pulses, zero `sec_tick`, `hyb_sec`=0.

Source files
------------

// File: rtl/step_pulse_pkg.sv
// Shared types, rate constants and the period helper for step_pulse_gen.
package step_pulse_pkg;

  typedef enum logic [1:0] {
    MODE_WALK = 2'd0,
    MODE_JOG  = 2'd1,
    MODE_RUN  = 2'd2,
    MODE_HYB  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STEADY,
    ST_HYBRID,
    ST_DONE
  } state_e;

  localparam int unsigned RATE_WALK = 32;
  localparam int unsigned RATE_JOG  = 64;
  localparam int unsigned RATE_RUN  = 128;
  localparam int unsigned HYB_SECS  = 9;

  // Hybrid schedule indexed by hybrid second 1..9; other indices are never selected.
  function automatic int unsigned hyb_rate(input int unsigned sec);
    case (sec)
      1:       return 20;
      2:       return 33;
      3:       return 66;
      4:       return 27;
      5:       return 70;
      6:       return 30;
      7:       return 19;
      8:       return 30;
      9:       return 33;
      default: return RATE_WALK;
    endcase
  endfunction

  function automatic int unsigned step_period(input int unsigned clk_hz, input int unsigned rate);
    return clk_hz / rate;
  endfunction

endpackage

// File: rtl/step_period_counter.sv
// Period counter for step_pulse_gen: per_cnt wraps at P-1, emit caps pulses at R per second.
module step_period_counter
  import step_pulse_pkg::*;
#(
  parameter int unsigned CNT_W = 27
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             sec_wrap,
  input  logic [CNT_W-1:0] period_m1,
  input  logic [7:0]       rate,
  output logic             fire
);

  logic [CNT_W-1:0] per_cnt;
  logic [7:0]       emit;

  assign fire = en && (per_cnt == period_m1) && (emit < rate);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_cnt <= '0;
      emit    <= '0;
    end else if (clr) begin
      per_cnt <= '0;
      emit    <= '0;
    end else if (en) begin
      if (sec_wrap) begin
        per_cnt <= '0;
        emit    <= '0;
      end else begin
        per_cnt <= (per_cnt == period_m1) ? '0 : per_cnt + CNT_W'(1);
        if (fire) emit <= emit + 8'd1;
      end
    end
  end

endmodule

// File: rtl/step_pulse_gen.sv
// Step-pulse generator: walk/jog/run rates plus a 9-second hybrid profile.
// Optional hybrid profile enabled by defining STEP_PULSE_HYBRID_EN.
module step_pulse_gen #(
  parameter int unsigned CLK_HZ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] mode,
  output logic       pulse,
  output logic       sec_tick,
  output logic [3:0] hyb_sec,
  output logic       hyb_done
);
  import step_pulse_pkg::*;

  localparam int unsigned      CNT_W    = $clog2(CLK_HZ);
  localparam logic [CNT_W-1:0] SEC_MAX  = CNT_W'(CLK_HZ - 1);
  localparam logic [CNT_W-1:0] PM1_WALK = CNT_W'(step_period(CLK_HZ, RATE_WALK) - 1);
  localparam logic [CNT_W-1:0] PM1_JOG  = CNT_W'(step_period(CLK_HZ, RATE_JOG) - 1);
  localparam logic [CNT_W-1:0] PM1_RUN  = CNT_W'(step_period(CLK_HZ, RATE_RUN) - 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic             start_q, start_d;
  logic [CNT_W-1:0] sec_cnt, sec_d;
  logic             pulse_d, tick_d;
  logic             go, restart, sec_wrap;
  logic             cnt_clr, cnt_en, fire;
  logic [CNT_W-1:0] period_m1;
  logic [7:0]       rate;

`ifdef STEP_PULSE_HYBRID_EN
  logic [3:0]       hyb_q, hyb_d;
  logic [CNT_W-1:0] hyb_pm1 [16];
  logic [7:0]       hyb_rt  [16];

  for (genvar g = 0; g < 16; g++) begin : g_hyb
    assign hyb_pm1[g] = CNT_W'(step_period(CLK_HZ, hyb_rate(g)) - 1);
    assign hyb_rt[g]  = 8'(hyb_rate(g));
  end

  assign go       = run;
  assign hyb_sec  = (state_q == ST_HYBRID) ? hyb_q : '0;
  assign hyb_done = (state_q == ST_DONE);
`else
  assign go       = run && (mode != MODE_HYB);
  assign hyb_sec  = '0;
  assign hyb_done = 1'b0;
`endif

  assign restart  = (state_q != ST_IDLE) && (mode != mode_q);
  assign sec_wrap = (sec_cnt == SEC_MAX);

  always_comb begin
    period_m1 = PM1_WALK;
    rate      = 8'(RATE_WALK);
    case (mode_q)
      MODE_JOG: begin period_m1 = PM1_JOG; rate = 8'(RATE_JOG); end
      MODE_RUN: begin period_m1 = PM1_RUN; rate = 8'(RATE_RUN); end
`ifdef STEP_PULSE_HYBRID_EN
      MODE_HYB: begin period_m1 = hyb_pm1[hyb_q]; rate = hyb_rt[hyb_q]; end
`endif
      default: ;
    endcase
  end

  // Entry cycle (start_q) holds counters at 0 so the first counted cycle follows the entry edge.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = 1'b0;
    sec_d   = sec_cnt;
    pulse_d = 1'b0;
    tick_d  = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
`ifdef STEP_PULSE_HYBRID_EN
    hyb_d   = hyb_q;
`endif
    if (!go) begin
      state_d = ST_IDLE;
      sec_d   = '0;
      cnt_clr = 1'b1;
`ifdef STEP_PULSE_HYBRID_EN
      hyb_d   = '0;
`endif
    end else if (state_q == ST_IDLE || restart) begin
      state_d = ST_STEADY;
      mode_d  = mode_e'(mode);
      start_d = 1'b1;
      sec_d   = '0;
      cnt_clr = 1'b1;
`ifdef STEP_PULSE_HYBRID_EN
      hyb_d   = '0;
      if (mode == MODE_HYB) begin
        state_d = ST_HYBRID;
        hyb_d   = 4'd1;
      end
`endif
    end else if (!start_q && state_q != ST_DONE) begin
      cnt_en  = 1'b1;
      pulse_d = fire;
      tick_d  = sec_wrap;
      sec_d   = sec_wrap ? '0 : sec_cnt + CNT_W'(1);
`ifdef STEP_PULSE_HYBRID_EN
      if (sec_wrap && state_q == ST_HYBRID) begin
        if (hyb_q == 4'(HYB_SECS)) begin
          state_d = ST_DONE;
          hyb_d   = '0;
        end else begin
          hyb_d   = hyb_q + 4'd1;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_WALK;
      start_q  <= 1'b0;
      sec_cnt  <= '0;
      pulse    <= 1'b0;
      sec_tick <= 1'b0;
`ifdef STEP_PULSE_HYBRID_EN
      hyb_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      sec_cnt  <= sec_d;
      pulse    <= pulse_d;
      sec_tick <= tick_d;
`ifdef STEP_PULSE_HYBRID_EN
      hyb_q    <= hyb_d;
`endif
    end
  end

  step_period_counter #(
    .CNT_W(CNT_W)
  ) u_per (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .en       (cnt_en),
    .sec_wrap (sec_wrap),
    .period_m1(period_m1),
    .rate     (rate),
    .fire     (fire)
  );

endmodule

// File: tb/tb_step_pulse_gen.sv
// Self-checking bench for step_pulse_gen (CLK_HZ=1280); honours STEP_PULSE_HYBRID_EN.
module tb_step_pulse_gen;
  import step_pulse_pkg::*;

  localparam int unsigned CLK_HZ = 1280;
`ifdef STEP_PULSE_HYBRID_EN
  localparam bit HYB_EN = 1'b1;
`else
  localparam bit HYB_EN = 1'b0;
`endif
  localparam int HYB_R [9] = '{20, 33, 66, 27, 70, 30, 19, 30, 33};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       run = 1'b0;
  logic [1:0] mode = 2'd0;
  logic       pulse, sec_tick, hyb_done;
  logic [3:0] hyb_sec;

  step_pulse_gen #(.CLK_HZ(CLK_HZ)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .mode(mode),
    .pulse(pulse), .sec_tick(sec_tick), .hyb_sec(hyb_sec), .hyb_done(hyb_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: age = edges since (re)entry; second position derived arithmetically.
  bit m_active = 1'b0;
  int m_mode = 0;
  int m_age = 0;
  int mism = 0, first_t = 0;
  int dut_p = 0, dut_t = 0, sec_p = 0;
  int sec_log [$];
  bit e_p, e_t, e_hd;
  int e_hs;

  function automatic void model_out(output bit p, output bit t, output int hs, output bit hd);
    int v, sidx, pos, r, per, s;
    p = 1'b0; t = 1'b0; hs = 0; hd = 1'b0;
    if (!m_active) return;
    if (m_age >= 2) begin
      v = m_age - 2;
      sidx = v / CLK_HZ;
      pos = v % CLK_HZ;
      if (m_mode != 3 || sidx < 9) begin
        if (m_mode == 3) r = HYB_R[sidx];
        else r = 32 << m_mode;
        per = CLK_HZ / r;
        p = ((pos + 1) % per == 0) && ((pos + 1) / per <= r);
        t = (pos == CLK_HZ - 1);
      end
    end
    if (m_mode == 3) begin
      s = (m_age == 0) ? 0 : (m_age - 1) / CLK_HZ;
      hs = (s < 9) ? s + 1 : 0;
      hd = (s >= 9);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (!rst_n || !(run && (mode != 2'd3 || HYB_EN))) m_active = 1'b0;
    else if (!m_active || int'(mode) != m_mode) begin
      m_active = 1'b1;
      m_mode = int'(mode);
      m_age = 0;
      sec_p = 0;
    end else m_age++;
    model_out(e_p, e_t, e_hs, e_hd);
    if (pulse !== e_p || sec_tick !== e_t || int'(hyb_sec) !== e_hs || hyb_done !== e_hd) begin
      if (mism == 0) first_t = int'($time);
      mism++;
    end
    if (pulse) begin dut_p++; sec_p++; end
    if (sec_tick) begin dut_t++; sec_log.push_back(sec_p); sec_p = 0; end
  end

  int mism_base = 0;
  task automatic check_model(input string name);
    chk({name, "_vs_model_mismatch_cycles"}, mism - mism_base, 0);
    if (mism != mism_base) $display("  first divergence at time %0d", first_t);
    mism_base = mism;
  endtask

  task automatic go_idle();
    @(negedge clk);
    run = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  typedef struct {
    bit         run;
    logic [1:0] mode;
    int         cycles;
    int         exp_p;
    int         exp_t;
    int         exp_hs;
    bit         exp_hd;
  } vec_t;

  vec_t vecs [6];

  initial begin
    #50_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, t0, l0, n, len;

    vecs[0] = '{1'b1, 2'd0, 2562, 64, 2, 0, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 1282, 128, 1, 0, 1'b0};
    vecs[2] = '{1'b1, 2'd1, 1282, 64, 1, 0, 1'b0};
    vecs[3] = '{1'b0, 2'd0, 100, 0, 0, 0, 1'b0};
`ifdef STEP_PULSE_HYBRID_EN
    vecs[4] = '{1'b1, 2'd3, 700, 10, 0, 1, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 12802, 328, 9, 0, 1'b1};
`else
    vecs[4] = '{1'b1, 2'd3, 700, 0, 0, 0, 1'b0};
    vecs[5] = '{1'b1, 2'd3, 2562, 0, 0, 0, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("reset_pulse", pulse, 0);
    chk("reset_sec_tick", sec_tick, 0);
    chk("reset_hyb_sec", hyb_sec, 0);
    chk("reset_hyb_done", hyb_done, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      go_idle();
      p0 = dut_p; t0 = dut_t; l0 = sec_log.size();
      run = vecs[i].run;
      mode = vecs[i].mode;
      repeat (vecs[i].cycles) @(posedge clk);
      #2;
      chk($sformatf("vec%0d_pulses", i), dut_p - p0, vecs[i].exp_p);
      chk($sformatf("vec%0d_ticks", i), dut_t - t0, vecs[i].exp_t);
      chk($sformatf("vec%0d_hyb_sec", i), hyb_sec, vecs[i].exp_hs);
      chk($sformatf("vec%0d_hyb_done", i), hyb_done, vecs[i].exp_hd);
      check_model($sformatf("vec%0d", i));
`ifdef STEP_PULSE_HYBRID_EN
      if (i == 5) begin
        chk("hyb_seconds_logged", sec_log.size() - l0, 9);
        for (int j = 0; j < 9; j++)
          if (l0 + j < sec_log.size())
            chk($sformatf("hyb_sec%0d_pulses", j + 1), sec_log[l0 + j], HYB_R[j]);
      end
`endif
    end

    // Mode change mid-run: restart, first jog pulse 21 edges later, tick realigned.
    go_idle();
    mode = 2'd2; run = 1'b1;
    repeat (500) @(posedge clk);
    @(negedge clk);
    mode = 2'd1;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (pulse) break;
    end
    chk("modechg_first_pulse_delay", n, 21);
    while (n < 3000) begin
      @(posedge clk); #1; n++;
      if (sec_tick) break;
    end
    chk("modechg_first_tick_delay", n, 1281);
    check_model("modechg");

    // Run drop in the cycle where per_cnt = P-1 suppresses the pulse.
    go_idle();
    mode = 2'd2; run = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drop_pre_per_cnt", int'(dut.u_per.per_cnt), 9);
    run = 1'b0;
    @(posedge clk); #1;
    chk("drop_pulse", pulse, 0);
    chk("drop_state_idle", int'(dut.state_q), int'(ST_IDLE));
    chk("drop_sec_cnt", int'(dut.sec_cnt), 0);
    chk("drop_per_cnt", int'(dut.u_per.per_cnt), 0);
    chk("drop_emit", int'(dut.u_per.emit), 0);
    repeat (5) @(posedge clk);
    check_model("drop");

    // Async reset while a pulse is high, then fresh start.
    go_idle();
    mode = 2'd0; run = 1'b1;
    repeat (700) @(posedge clk);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1; n++;
      if (pulse) break;
    end
    chk("areset_pulse_before", pulse, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_pulse", pulse, 0);
    chk("areset_sec_tick", sec_tick, 0);
    chk("areset_hyb_sec", hyb_sec, 0);
    chk("areset_sec_cnt", int'(dut.sec_cnt), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    n = 0;
    while (n < 200) begin
      @(posedge clk); #1; n++;
      if (pulse) break;
    end
    chk("areset_restart_first_pulse", n, 41);
    check_model("areset");

    // Randomized run/mode segments against the model.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      run = ($urandom_range(0, 5) != 0);
      mode = 2'($urandom_range(0, 3));
      len = int'($urandom_range(50, 1500));
      repeat (len) @(negedge clk);
    end
    check_model("random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
